// File: rtl/add16.sv
// Ripple-carry adder with a combinational sum output and a one-cycle registered
// result carrying the unsigned carry-out and the signed overflow flag.

module add16_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module add16_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  add16_ha u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  add16_ha u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module add16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] out_o,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum_q_o,
  output logic             carry_q_o,
  output logic             ovf_q_o,
  output logic             valid_o
);
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } res_t;

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum;
  res_t             res_d, res_q;
  logic             valid_q;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    add16_fa u_fa (
      .a (a_i[i]),
      .b (b_i[i]),
      .ci(chain[i]),
      .s (sum[i]),
      .co(chain[i+1])
    );
  end

  assign out_o = sum;

  // Overflow: like-signed operands producing a result of the opposite sign.
  assign res_d.sum   = sum;
  assign res_d.carry = chain[WIDTH];
  assign res_d.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) res_q <= res_d;
    end
  end

  assign sum_q_o   = res_q.sum;
  assign carry_q_o = res_q.carry;
  assign ovf_q_o   = res_q.ovf;
  assign valid_o   = valid_q;
endmodule

// File: tb/tb_add16.sv
// Bench for add16: directed vector table, reset/valid corner sequences and a
// randomized run scored against an arithmetic reference.

module tb_add16;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] a_i = '0, b_i = '0;
  logic        valid_i = 1'b0;
  logic [15:0] out_o, sum_q_o;
  logic        carry_q_o, ovf_q_o, valid_o;

  int checks = 0;
  int errors = 0;

  // reference registered state
  logic [15:0] m_sum;
  logic        m_carry, m_ovf, m_valid;

  add16 #(.WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .out_o(out_o),
    .valid_i(valid_i), .sum_q_o(sum_q_o), .carry_q_o(carry_q_o),
    .ovf_q_o(ovf_q_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] a, b, out;
    logic        carry, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
    int unsigned t = int'(a) + int'(b);
    return t[15:0];
  endfunction

  function automatic logic ref_carry(input logic [15:0] a, input logic [15:0] b);
    return (int'(a) + int'(b)) >= 65536;
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
    int r = int'($signed(a)) + int'($signed(b));
    return (r > 32767) || (r < -32768);
  endfunction

  // Called at a negedge: drive, check the combinational sum, then advance the
  // model across the next rising edge and compare registered outputs.
  task automatic step(input logic rst, input logic vld, input logic [15:0] a, input logic [15:0] b);
    rst_i = rst; valid_i = vld; a_i = a; b_i = b;
    #1;
    chk("out_o", out_o, ref_sum(a, b));
    if (rst) begin
      m_sum = '0; m_carry = 0; m_ovf = 0; m_valid = 0;
    end else begin
      m_valid = vld;
      if (vld) begin
        m_sum = ref_sum(a, b); m_carry = ref_carry(a, b); m_ovf = ref_ovf(a, b);
      end
    end
    @(negedge clk_i);
    chk("sum_q_o", sum_q_o, m_sum);
    chk("carry_q_o", carry_q_o, m_carry);
    chk("ovf_q_o", ovf_q_o, m_ovf);
    chk("valid_o", valid_o, m_valid);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
    vecs[4] = '{16'hAAAA, 16'h3BF1, 16'hE69B, 1'b0, 1'b0};
    vecs[5] = '{16'h1234, 16'h9876, 16'hAAAA, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    // reset state; reset held alongside valid_i must win
    @(negedge clk_i);
    step(1, 0, 16'h0000, 16'h0000);
    step(1, 1, 16'h7FFF, 16'h0001);
    chk("rst_sum", sum_q_o, 16'h0000);
    chk("rst_valid", valid_o, 1'b0);

    // table vectors, each captured with valid_i=1
    foreach (vecs[i]) begin
      rst_i = 0; valid_i = 1; a_i = vecs[i].a; b_i = vecs[i].b;
      #1;
      chk("vec_out", out_o, vecs[i].out);
      @(negedge clk_i);
      chk("vec_sum_q", sum_q_o, vecs[i].out);
      chk("vec_carry_q", carry_q_o, vecs[i].carry);
      chk("vec_ovf_q", ovf_q_o, vecs[i].ovf);
      chk("vec_valid", valid_o, 1'b1);
      m_sum = vecs[i].out; m_carry = vecs[i].carry; m_ovf = vecs[i].ovf; m_valid = 1;
    end

    // single valid pulse: valid_o high one cycle, result held afterward
    step(0, 1, 16'h8000, 16'h8000);
    step(0, 0, 16'h1111, 16'h2222);
    chk("pulse_hold_sum", sum_q_o, 16'h0000);
    chk("pulse_hold_carry", carry_q_o, 1'b1);
    step(0, 0, 16'h3333, 16'h4444);

    // operand wiggle between edges touches only out_o
    step(0, 1, 16'h1234, 16'h9876);
    a_i = 16'hFFFF; b_i = 16'h0002; valid_i = 0;
    #2;
    chk("wiggle_out", out_o, 16'h0001);
    chk("wiggle_sum_q", sum_q_o, 16'hAAAA);

    // reset mid-stream discards the capture; out_o keeps tracking under reset
    @(negedge clk_i);
    step(0, 1, 16'h7FFF, 16'h7FFF);
    step(1, 1, 16'h0F0F, 16'h0101);
    chk("rst_out_tracks", out_o, 16'h1010);
    step(0, 1, 16'h0005, 16'h0006);
    chk("post_rst_sum", sum_q_o, 16'h000B);

    // randomized run
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
           16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add16.md
ADD16 -- requirements
Module: add16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is required to be supported.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port a_i  input  16  operand A, unsigned or two's complement.
REQ-005 SHALL have port b_i  input  16  operand B, unsigned or two's complement.
REQ-006 SHALL have port out_o  output  16  combinational sum of a_i and b_i.
REQ-007 SHALL have port valid_i  input  1  qualifies a_i/b_i for capture into the registered result.
REQ-008 SHALL have port sum_q_o  output  16  registered sum.
REQ-009 SHALL have port carry_q_o  output  1  registered unsigned carry-out, bit 16.
REQ-010 SHALL have port ovf_q_o  output  1  registered signed overflow.
REQ-011 SHALL have port valid_o  output  1  registered result valid.

Function
REQ-012 out_o SHALL equal (a_i + b_i) mod 2^16 combinationally, with no clock or reset dependency.
REQ-013 out_o SHALL settle within the same evaluation step as an input change; no latch is permitted.
REQ-014 The adder SHALL be structured as a 16-stage ripple-carry chain of full adders, each built from two half adders plus OR, with carry-in of bit 0 tied to 0.
REQ-015 Carry SHALL be the carry out of bit 15; overflow SHALL be (a[15] == b[15]) && (sum[15] != a[15]).
REQ-016 On a rising clk_i edge with valid_i=1 and rst_i=0, sum_q_o, carry_q_o and ovf_q_o SHALL load the sum, carry and overflow of the current a_i/b_i, and valid_o SHALL become 1.
REQ-017 On a rising edge with valid_i=0 and rst_i=0, sum_q_o, carry_q_o and ovf_q_o SHALL hold their values and valid_o SHALL become 0.
REQ-018 Registered latency SHALL be exactly 1 cycle from the valid_i edge to valid_o.
REQ-019 There SHALL be no backpressure; a new capture is accepted on every valid_i=1 cycle.
REQ-020 Wrap-around: results of 2^16 or more SHALL truncate to 16 bits with carry=1; no saturation.
REQ-021 Operand changes between clock edges SHALL affect only out_o, never the registered outputs.

Reset
REQ-022 While rst_i=1 at a rising edge, sum_q_o SHALL become 0x0000, and carry_q_o, ovf_q_o and valid_o SHALL become 0.
REQ-023 rst_i SHALL take priority over valid_i on the same edge.
REQ-024 out_o SHALL be unaffected by reset and continue tracking the inputs.
REQ-025 Reset mid-stream SHALL discard the pending result; the first capture after reset deasserts SHALL follow REQ-016.

Verification
REQ-026 0x0000 + 0x0000 -> out_o=0x0000; registered result 0x0000, carry 0, ovf 0.
REQ-027 0xFFFF + 0x0000, and 0x0000 + 0xFFFF -> out_o=0xFFFF, carry 0, ovf 0.
REQ-028 0xFFFF + 0xFFFF -> out_o=0xFFFE, carry 1, ovf 0.
REQ-029 0xAAAA + 0x3BF1 -> out_o=0xE69B; 0x1234 + 0x9876 -> out_o=0xAAAA; carry 0, ovf 0 for both.
REQ-030 0x7FFF + 0x0001 -> 0x8000 with ovf 1 and carry 0; 0x8000 + 0x8000 -> 0x0000 with carry 1 and ovf 1.
REQ-031 valid_i=1 with rst_i=1 on the same edge -> all registered outputs are 0; a valid_i pulse then gives valid_o high for exactly 1 cycle with the result held afterward.
